uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
Serial-to-parallel UART receiver. It is the inbound counterpart of the existing uart_tx and uses the same CLOCK_FREQUENCY/BAUD_RATE/WORD_WIDTH parameter set.
- Samples an asynchronous 8N1-style line and presents each received word on a push-style sink handshake (dout/we/full), the mirror of uart_tx's din/empty/re pull handshake.
- Feeds command parsing from the host, e.g. button/counter control over the same USB-UART bridge.

Parameters:
- CLOCK_FREQUENCY, 32'd27_000_000, system clock in Hz.
- BAUD_RATE, 32'd115200, line bit rate.
- WORD_WIDTH, 32'd8, data bits per frame, LSB first; legal range 5..9.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- din  in  1  asynchronous serial line; idles high.
- full  in  1  sink cannot accept a word this cycle.
- dout  out  WORD_WIDTH  last received word; held stable until the next accepted word.
- we  out  1  one-cycle strobe: dout is valid, sink captures it.
- frame_err  out  1  one-cycle strobe: stop bit sampled low.
- ovf  out  1  one-cycle strobe: word completed while full=1; the word is dropped.

Behaviour:
- Reset values: dout=0, we=0, frame_err=0, ovf=0, state=IDLE, both synchronizer flops=1, counters=0.
- Reset mid-frame: the partial word is discarded; no strobe is produced. Reception resumes only on a fresh falling edge seen after reset.
- Timing constants:
  - DIV = CLOCK_FREQUENCY/BAUD_RATE, integer truncation. Defaults give 234.
  - HALF = DIV/2, which is 117.
  - Tick counter is $clog2(DIV)+1 bits wide.
- Input path: 2-FF synchronizer on din, giving din_s. Falling-edge detect compares din_s with its previous value. Raw-to-din_s latency is 2 cycles.
- FSM states: IDLE, START, DATA, STOP, FLUSH.
  - IDLE: on a din_s falling edge at cycle t0, go to START and clear the tick counter.
  - START: at t0+HALF, sample din_s.
    - Sample=1: false start, return to IDLE, no strobe.
    - Sample=0: go to DATA, clear the bit index.
  - DATA: sample bit i at t0+HALF+(i+1)*DIV and shift it in LSB first. After bit WORD_WIDTH-1, go to STOP.
  - STOP: sample at t0+HALF+(WORD_WIDTH+1)*DIV.
    - Sample=1 and full=0: in the next cycle, dout gets the shift register value and we=1. Go to IDLE.
    - Sample=1 and full=1: in the next cycle, ovf=1; dout and we are unchanged. Go to IDLE.
    - Sample=0: in the next cycle, frame_err=1 with no we; dout is unchanged. Go to FLUSH.
  - FLUSH: wait until din_s=1 (break/line-low condition), then go to IDLE. A low line never produces repeated frames.
- Return to IDLE happens mid stop bit. A start bit immediately following is therefore detected. Back-to-back frames are required to be received without loss.
- we, ovf and frame_err are mutually exclusive and each lasts exactly 1 cycle.
- full is sampled only in the stop-sample cycle. There is no internal buffering beyond dout.
- Overall latency: we asserts 1 cycle after the stop sample, which is 2+HALF+(WORD_WIDTH+1)*DIV+1 cycles after the raw falling edge.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined: add a PARITY state between DATA and STOP. The parity bit is sampled one DIV after the last data bit, and STOP moves one DIV later. Parity is even; add parameter PARITY_ODD, default 0, to select odd.
- Defined: new output port parity_err, 1 bit. It strobes one cycle in place of we on mismatch when the stop bit is good. The word is dropped and dout is unchanged.
- Undefined: no PARITY state, no parity_err port, frame = start + WORD_WIDTH + stop.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding localparams (IDLE, START, DATA, PARITY, STOP, FLUSH).
  - Divider constant function calc_div(freq, baud), also usable by uart_tx.
- Sub-module uart_rx_sync: 2-FF synchronizer plus falling-edge detector.
  - Ports: clk, rst, din, din_s, fall.
  - Resets to 1 so that no spurious edge occurs.

Test Plan:
- Byte 8'h55 at 115200 baud, full=0 -> single we pulse, dout=8'h55, no other strobes. Check latency = 2+117+9*234+1 cycles from the raw falling edge.
- Back-to-back 8'hA3 then 8'h0F, with no idle gap between frames -> two we pulses, dout=8'hA3 then 8'h0F.
- Low glitch on din of 50 cycles -> false start; no strobe; FSM back in IDLE. A following 8'h3C frame is received correctly.
- Frame 8'hFF with the stop bit forced low, then the line held low for 3 bit times -> one frame_err, no we, dout keeps its previous value. No further strobes until the line returns high and a new frame arrives.
- full=1 during 8'h81 -> one ovf, no we, dout unchanged. The next frame 8'h18 with full=0 -> we, dout=8'h18.
- rst asserted for 1 cycle during data bit 4 -> no strobes. The next complete frame 8'hC6 -> we, dout=8'hC6.
- With UART_RX_PARITY_EN defined: 8'h07 with the correct even parity bit 1 -> we. The same byte with parity bit 0 -> parity_err, no we.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM state encoding, baud divider and parity helpers.
// Used by uart_rx, and reusable by uart_tx.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4,
      FLUSH  = 3'd5
   } uart_state_t;

   // Clock cycles per bit, truncated.
   function automatic logic [31:0] calc_div(input logic [31:0] freq, input logic [31:0] baud);
      calc_div = freq / baud;
   endfunction

   // Parity bit that must accompany bits: even parity when odd=0, odd parity when odd=1.
   function automatic logic calc_parity(input logic [8:0] bits, input logic odd);
      calc_parity = (^bits) ^ odd;
   endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous serial line plus a falling-edge detector.
// All flops reset to the idle level (1) so that reset never fabricates an edge.
module uart_rx_sync (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic din_s,
   output logic fall
);

   logic meta;
   logic prev;

   // Synchronizer chain and one-cycle history of the synchronized line.
   always_ff @(posedge clk) begin
      if (rst) begin
         meta  <= 1'b1;
         din_s <= 1'b1;
         prev  <= 1'b1;
      end else begin
         meta  <= din;
         din_s <= meta;
         prev  <= din_s;
      end
   end

   assign fall = prev & ~din_s;

endmodule

// File: rtl/uart_rx.sv
// uart_rx: asynchronous serial receiver presenting words on a push-style sink (dout/we/full).
// Define UART_RX_PARITY_EN to add a parity bit (even, or odd via PARITY_ODD) and parity_err.
module uart_rx
   import uart_pkg::*;
#(
   parameter logic [31:0] CLOCK_FREQUENCY = 32'd27_000_000,
   parameter logic [31:0] BAUD_RATE       = 32'd115200,
   parameter logic [31:0] WORD_WIDTH      = 32'd8
`ifdef UART_RX_PARITY_EN
   ,
   parameter logic        PARITY_ODD      = 1'b0
`endif
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  din,
   input  logic                  full,
   output logic [WORD_WIDTH-1:0] dout,
   output logic                  we,
   output logic                  frame_err,
   output logic                  ovf
`ifdef UART_RX_PARITY_EN
   ,
   output logic                  parity_err
`endif
);

   localparam logic [31:0]   DIV       = calc_div(CLOCK_FREQUENCY, BAUD_RATE);
   localparam logic [31:0]   HALF      = DIV / 32'd2;
   localparam int            CW        = $clog2(DIV) + 1;
   localparam int            IW        = $clog2(WORD_WIDTH);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 32'd1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF - 32'd1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(WORD_WIDTH - 32'd1);

   logic                  din_s;
   logic                  fall;

   uart_state_t           state;
   uart_state_t           state_next;
   logic [CW-1:0]         cnt;
   logic [CW-1:0]         cnt_next;
   logic [IW-1:0]         idx;
   logic [IW-1:0]         idx_next;
   logic [WORD_WIDTH-1:0] shreg;
   logic [WORD_WIDTH-1:0] shreg_next;
   logic [WORD_WIDTH-1:0] dout_next;
   logic                  we_next;
   logic                  frame_err_next;
   logic                  ovf_next;
`ifdef UART_RX_PARITY_EN
   logic                  par_bit;
   logic                  par_bit_next;
   logic                  parity_err_next;
`endif

   uart_rx_sync u_sync (
      .clk   (clk),
      .rst   (rst),
      .din   (din),
      .din_s (din_s),
      .fall  (fall)
   );

   // State, timing counters, shift register and registered sink outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= {CW{1'b0}};
         idx       <= {IW{1'b0}};
         shreg     <= {WORD_WIDTH{1'b0}};
         dout      <= {WORD_WIDTH{1'b0}};
         we        <= 1'b0;
         frame_err <= 1'b0;
         ovf       <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bit    <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state     <= state_next;
         cnt       <= cnt_next;
         idx       <= idx_next;
         shreg     <= shreg_next;
         dout      <= dout_next;
         we        <= we_next;
         frame_err <= frame_err_next;
         ovf       <= ovf_next;
`ifdef UART_RX_PARITY_EN
         par_bit    <= par_bit_next;
         parity_err <= parity_err_next;
`endif
      end
   end

   // Next-state and output logic; every sample point is a counter terminal value.
   always_comb begin
      state_next     = state;
      cnt_next       = cnt + CW'(1);
      idx_next       = idx;
      shreg_next     = shreg;
      dout_next      = dout;
      we_next        = 1'b0;
      frame_err_next = 1'b0;
      ovf_next       = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit_next    = par_bit;
      parity_err_next = 1'b0;
`endif
      case (state)
         IDLE: begin
            cnt_next = {CW{1'b0}};
            if (fall) begin
               state_next = START;
            end else begin
               state_next = IDLE;
            end
         end
         START: begin
            if (cnt == HALF_LAST) begin
               cnt_next = {CW{1'b0}};
               idx_next = {IW{1'b0}};
               if (din_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
               end
            end else begin
               state_next = START;
            end
         end
         DATA: begin
            if (cnt == DIV_LAST) begin
               cnt_next   = {CW{1'b0}};
               shreg_next = {din_s, shreg[WORD_WIDTH-1:1]};
               if (idx == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_next = PARITY;
`else
                  state_next = STOP;
`endif
               end else begin
                  idx_next = idx + IW'(1);
               end
            end else begin
               state_next = DATA;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == DIV_LAST) begin
               cnt_next     = {CW{1'b0}};
               par_bit_next = din_s;
               state_next   = STOP;
            end else begin
               state_next = PARITY;
            end
         end
`else
         PARITY: begin
            state_next = IDLE;
         end
`endif
         // Leaving mid stop bit lets an immediately following start bit be caught.
         STOP: begin
            if (cnt == DIV_LAST) begin
               cnt_next = {CW{1'b0}};
               if (!din_s) begin
                  frame_err_next = 1'b1;
                  state_next     = FLUSH;
               end
`ifdef UART_RX_PARITY_EN
               else if (par_bit != calc_parity(9'(shreg), PARITY_ODD)) begin
                  parity_err_next = 1'b1;
                  state_next      = IDLE;
               end
`endif
               else if (full) begin
                  ovf_next   = 1'b1;
                  state_next = IDLE;
               end else begin
                  we_next    = 1'b1;
                  dout_next  = shreg;
                  state_next = IDLE;
               end
            end else begin
               state_next = STOP;
            end
         end
         FLUSH: begin
            cnt_next = {CW{1'b0}};
            if (din_s) begin
               state_next = IDLE;
            end else begin
               state_next = FLUSH;
            end
         end
         default: begin
            cnt_next   = {CW{1'b0}};
            state_next = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames from the test plan plus random frames,
// checked against a frame-level model of the expected strobes and words.
module tb_uart_rx;

   localparam int DIV  = 27_000_000 / 115_200;
   localparam int HALF = DIV / 2;
`ifdef UART_RX_PARITY_EN
   localparam int PAR = 1;
`else
   localparam int PAR = 0;
`endif
   localparam int LAT = 2 + HALF + (8 + PAR + 1) * DIV + 1;

   logic       clk  = 1'b0;
   logic       rst  = 1'b1;
   logic       din  = 1'b1;
   logic       full = 1'b0;
   logic [7:0] dout;
   logic       we;
   logic       frame_err;
   logic       ovf;
   logic       perr;
   logic [3:0] strb;
   logic [3:0] prev_strb = 4'b0000;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int start_cyc   = 0;
   int last_we_cyc = 0;
   int n_we = 0, n_ovf = 0, n_ferr = 0, n_perr = 0;
   int e_we = 0, e_ovf = 0, e_ferr = 0, e_perr = 0;
   logic [7:0] exp_q[$];
   logic [7:0] model_dout = 8'h00;

   uart_rx #(
      .CLOCK_FREQUENCY (32'd27_000_000),
      .BAUD_RATE       (32'd115200),
      .WORD_WIDTH      (32'd8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .full      (full),
      .dout      (dout),
      .we        (we),
      .frame_err (frame_err),
      .ovf       (ovf)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (perr)
`endif
   );
`ifndef UART_RX_PARITY_EN
   assign perr = 1'b0;
`endif

   assign strb = {we, ovf, frame_err, perr};

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Strobe monitor: exclusivity, single-cycle width, and word scoreboard.
   always @(negedge clk) begin
      if (strb != 4'b0000) begin
         chk("strobe_excl", $countones(strb), 1);
         chk("strobe_len", strb & prev_strb, 4'b0000);
      end
      if (we) begin
         n_we        <= n_we + 1;
         last_we_cyc <= cyc;
         chk("we_pending", exp_q.size() != 0, 1);
         if (exp_q.size() != 0) chk("we_data", dout, exp_q.pop_front());
      end
      if (ovf) n_ovf <= n_ovf + 1;
      if (frame_err) n_ferr <= n_ferr + 1;
      if (perr) n_perr <= n_perr + 1;
      prev_strb <= strb;
   end

   task automatic bit_out(input logic v, input logic do_rst);
      din = v;
      if (do_rst) begin
         repeat (DIV / 2) @(posedge clk);
         #1 rst = 1'b1;
         @(posedge clk);
         #1 rst = 1'b0;
         repeat (DIV - DIV / 2 - 1) @(posedge clk);
      end else begin
         repeat (DIV) @(posedge clk);
      end
      #1;
   endtask

   // rst_bit: 0 = start bit, 1..8 = data bit index+1, anything else = no reset.
   task automatic send(input logic [7:0] data, input logic stop_v, input logic bad_par,
                       input int rst_bit);
      start_cyc = cyc;
      bit_out(1'b0, rst_bit == 0);
      for (int i = 0; i < 8; i++) bit_out(data[i], rst_bit == i + 1);
      if (PAR != 0) bit_out((^data) ^ bad_par, 1'b0);
      bit_out(stop_v, 1'b0);
   endtask

   // Frame-level reference: which strobe a frame must produce and what dout becomes.
   task automatic expect_frame(input logic [7:0] data, input logic stop_v, input logic bad_par,
                               input logic full_v);
      if (!stop_v) e_ferr++;
      else if (PAR != 0 && bad_par) e_perr++;
      else if (full_v) e_ovf++;
      else begin
         e_we++;
         exp_q.push_back(data);
         model_dout = data;
      end
   endtask

   task automatic idle(input int n);
      din = 1'b1;
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic check_all(input string tag);
      chk({tag, ".we"}, n_we, e_we);
      chk({tag, ".ovf"}, n_ovf, e_ovf);
      chk({tag, ".ferr"}, n_ferr, e_ferr);
      chk({tag, ".perr"}, n_perr, e_perr);
      chk({tag, ".dout"}, dout, model_dout);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog cycles=%0d limit reached", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] d;
      logic       s;
      logic       f;
      logic       bp;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("rst.dout", dout, 8'h00);
      chk("rst.we", we, 1'b0);
      chk("rst.ferr", frame_err, 1'b0);
      chk("rst.ovf", ovf, 1'b0);
      rst = 1'b0;
      idle(20);

      expect_frame(8'h55, 1'b1, 1'b0, 1'b0);
      send(8'h55, 1'b1, 1'b0, -1);
      idle(10);
      chk("latency", last_we_cyc - start_cyc, LAT);
      check_all("b55");

      expect_frame(8'hA3, 1'b1, 1'b0, 1'b0);
      send(8'hA3, 1'b1, 1'b0, -1);
      expect_frame(8'h0F, 1'b1, 1'b0, 1'b0);
      send(8'h0F, 1'b1, 1'b0, -1);
      idle(10);
      check_all("b2b");

      din = 1'b0;
      repeat (50) @(posedge clk);
      #1;
      idle(2 * DIV);
      check_all("glitch");
      expect_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      send(8'h3C, 1'b1, 1'b0, -1);
      idle(10);
      check_all("b3c");

      expect_frame(8'hFF, 1'b0, 1'b0, 1'b0);
      send(8'hFF, 1'b0, 1'b0, -1);
      din = 1'b0;
      repeat (3 * DIV) @(posedge clk);
      #1;
      idle(2 * DIV);
      check_all("ferr");

      full = 1'b1;
      expect_frame(8'h81, 1'b1, 1'b0, 1'b1);
      send(8'h81, 1'b1, 1'b0, -1);
      full = 1'b0;
      idle(10);
      check_all("ovf");
      expect_frame(8'h18, 1'b1, 1'b0, 1'b0);
      send(8'h18, 1'b1, 1'b0, -1);
      idle(10);
      check_all("b18");

      send(8'hF5, 1'b1, 1'b0, 5);
      idle(10);
      model_dout = 8'h00;
      check_all("rst_mid");
      expect_frame(8'hC6, 1'b1, 1'b0, 1'b0);
      send(8'hC6, 1'b1, 1'b0, -1);
      idle(10);
      check_all("bc6");

`ifdef UART_RX_PARITY_EN
      expect_frame(8'h07, 1'b1, 1'b0, 1'b0);
      send(8'h07, 1'b1, 1'b0, -1);
      idle(10);
      check_all("par_ok");
      expect_frame(8'h07, 1'b1, 1'b1, 1'b0);
      send(8'h07, 1'b1, 1'b1, -1);
      idle(10);
      check_all("par_bad");
`endif

      for (int k = 0; k < 8; k++) begin
         d  = 8'($urandom);
         s  = ($urandom_range(0, 4) != 0);
         f  = ($urandom_range(0, 3) == 0);
         bp = ($urandom_range(0, 3) == 0);
         full = f;
         expect_frame(d, s, bp, f);
         send(d, s, bp, -1);
         full = 1'b0;
         if (!s) idle(2 * DIV);
         else idle($urandom_range(0, 2) * 37);
      end
      idle(10);
      check_all("rand");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
